// File: rtl/fperm_res_sink_if.sv
// Interface bundling the issue, result-bus and writeback signals of fperm_res_sink.
// The master side drives issue/bus/wb_rdy; the slave side is the sink itself.
interface fperm_res_sink_if #(
  parameter int TAG_W = 9
);
  logic             issue_vld;
  logic             issue_long;
  logic [TAG_W-1:0] issue_tag;
  logic [1:0]       issue_typ;
  logic             issue_stall;
  logic [67:0]      bus_in;
  logic             wb_vld;
  logic             wb_rdy;
  logic [TAG_W-1:0] wb_tag;
  logic [67:0]      wb_data;
  logic             type_err;

  modport master (
    output issue_vld, issue_long, issue_tag, issue_typ, bus_in, wb_rdy,
    input  issue_stall, wb_vld, wb_tag, wb_data, type_err
  );

  modport slave (
    input  issue_vld, issue_long, issue_tag, issue_typ, bus_in, wb_rdy,
    output issue_stall, wb_vld, wb_tag, wb_data, type_err
  );
endinterface

// File: rtl/fperm_res_sink.sv
// FP permute result-bus sink: tracks short/long ops in flight, captures the bus in the
// driver's slot, and buffers tagged results in a FWFT FIFO. Option: FPBUS_TYPECHK_EN.
module fperm_res_sink #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 9
) (
  input logic             clk,
  input logic             rst,
  fperm_res_sink_if.slave io
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = TAG_W + 68;

  logic [2:0]       r_p;
  logic [TAG_W-1:0] r_tag2, r_tag1, r_tag0;
  logic [AW:0]      r_count;
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [EW-1:0]    r_mem [DEPTH];

  logic          w_accept, w_collision, w_no_credit, w_stall;
  logic          w_vld, w_full, w_push, w_pop;
  logic [AW+1:0] w_need;
  logic [EW-1:0] w_head;

  // Credit counts every slot already in flight; a same-cycle pop is not credited.
  always_comb begin
    w_need = (AW+2)'(r_count) + (AW+2)'(r_p[0]) + (AW+2)'(r_p[1])
           + (AW+2)'(r_p[2]) + (AW+2)'(1);
  end

  assign w_no_credit    = (w_need > (AW+2)'(DEPTH));
  assign w_collision    = ~io.issue_long & r_p[1];
  assign w_stall        = io.issue_vld & (w_collision | w_no_credit);
  assign io.issue_stall = w_stall;
  assign w_accept       = io.issue_vld & ~w_stall;

  assign w_vld  = (r_count != '0);
  assign w_full = (r_count == (AW+1)'(DEPTH));
  assign w_push = r_p[0] & ~w_full;
  assign w_pop  = w_vld & io.wb_rdy;

  always_ff @(posedge clk) begin
    // NOTE: every sequential assignment is non-blocking so the slot shift reads old values.
    if (rst) begin
      r_p      <= '0;
      r_tag2   <= '0;
      r_tag1   <= '0;
      r_tag0   <= '0;
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      r_p[2] <= w_accept & io.issue_long;
      r_p[1] <= r_p[2];
      r_p[0] <= r_p[1] | (w_accept & ~io.issue_long);
      r_tag2 <= io.issue_tag;
      r_tag1 <= r_tag2;
      r_tag0 <= (w_accept & ~io.issue_long) ? io.issue_tag : r_tag1;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: storage has no reset; the count gates every read, so stale entries are never seen.
  always_ff @(posedge clk) begin
    if (!rst && w_push) r_mem[r_wr_ptr] <= {r_tag0, io.bus_in};
  end

  assign w_head     = r_mem[r_rd_ptr];
  assign io.wb_vld  = w_vld;
  assign io.wb_tag  = w_vld ? w_head[EW-1:68] : '0;
  assign io.wb_data = w_vld ? w_head[67:0]    : '0;

`ifdef FPBUS_TYPECHK_EN
  logic [1:0] r_typ2, r_typ1, r_typ0;
  logic       r_type_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_typ2     <= '0;
      r_typ1     <= '0;
      r_typ0     <= '0;
      r_type_err <= 1'b0;
    end else begin
      r_typ2 <= io.issue_typ;
      r_typ1 <= r_typ2;
      r_typ0 <= (w_accept & ~io.issue_long) ? io.issue_typ : r_typ1;
      if (r_p[0] && (io.bus_in[67:66] != r_typ0)) r_type_err <= 1'b1;
    end
  end

  assign io.type_err = r_type_err;
`else
  logic w_unused_typ;
  assign w_unused_typ = ^io.issue_typ;
  assign io.type_err  = 1'b0;
`endif

  a_no_full_push: assert property (@(posedge clk) disable iff (rst) !(r_p[0] && w_full));

endmodule
